// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control unit: walks each instruction through fetch, decode,
// execute, memory and writeback, driving the datapath selects and the ALU operation.
module mc_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  output logic        IorD,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSrc,
  output logic        PCEn,
  output logic [3:0]  ALUControl,
  output logic [3:0]  State,
  output logic [31:0] InstrCount
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_instr_count;
  logic        w_retire;

  logic       w_iord, w_mem_write, w_ir_write, w_reg_dst, w_memto_reg, w_reg_write;
  logic       w_alu_src_a, w_pc_en;
  logic [1:0] w_alu_src_b, w_pc_src;
  logic [3:0] w_alu_control;

  // An instruction retires on the edge that returns to FETCH from any other state.
  assign w_retire = (w_next_state == S_FETCH) && (r_state != S_FETCH);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) r_instr_count <= r_instr_count + 32'd1;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state  = S_FETCH;
    w_iord        = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    w_reg_dst     = 1'b0;
    w_memto_reg   = 1'b0;
    w_reg_write   = 1'b0;
    w_alu_src_a   = 1'b0;
    w_alu_src_b   = 2'b00;
    w_pc_src      = 2'b00;
    w_pc_en       = 1'b0;
    w_alu_control = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b01;
        w_ir_write   = 1'b1;
        w_pc_en      = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        case (Op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_RTYPE:     w_next_state = S_EXEC;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_ADDI:      w_next_state = S_ADDIEX;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_next_state = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord       = 1'b1;
        w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        w_memto_reg = 1'b1;
        w_reg_write = 1'b1;
      end
      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXEC: begin
        w_alu_src_a  = 1'b1;
        w_next_state = S_ALUWB;
        case (Funct)
          6'b100000: w_alu_control = ALU_ADD;
          6'b100010: w_alu_control = ALU_SUB;
          6'b100100: w_alu_control = ALU_AND;
          6'b100101: w_alu_control = ALU_OR;
          6'b101010: w_alu_control = ALU_SLT;
          default:   w_alu_control = ALU_BAD;
        endcase
      end
      S_ALUWB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a   = 1'b1;
        w_alu_control = ALU_SUB;
        w_pc_src      = 2'b01;
        w_pc_en       = Zero;
      end
      S_ADDIEX: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_next_state = S_ADDIWB;
      end
      S_ADDIWB: w_reg_write = 1'b1;
      S_JUMP: begin
        w_pc_src = 2'b10;
        w_pc_en  = 1'b1;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  // Write enables are suppressed while reset is held, even mid-instruction.
  assign MemWrite   = w_mem_write & ~reset;
  assign IRWrite    = w_ir_write  & ~reset;
  assign RegWrite   = w_reg_write & ~reset;
  assign PCEn       = w_pc_en     & ~reset;
  assign IorD       = w_iord;
  assign RegDst     = w_reg_dst;
  assign MemtoReg   = w_memto_reg;
  assign ALUSrcA    = w_alu_src_a;
  assign ALUSrcB    = w_alu_src_b;
  assign PCSrc      = w_pc_src;
  assign ALUControl = w_alu_control;
  assign State      = r_state;
  assign InstrCount = r_instr_count;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: table of instructions with expected state paths,
// per-cycle expectations queued and compared at the falling edge.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Op, Funct;
  logic        Zero;
  logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [3:0]  ALUControl, State;
  logic [31:0] InstrCount;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn), .ALUControl(ALUControl),
    .State(State), .InstrCount(InstrCount)
  );

  typedef struct packed {
    logic       iord, mem_write, ir_write, reg_dst, memto_reg, reg_write, src_a;
    logic [1:0] src_b, pc_src;
    logic       pc_en;
    logic [3:0] alu;
  } ctrl_t;

  typedef struct {
    logic [3:0]  state;
    ctrl_t       ctrl;
    logic [31:0] count;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [23:0] path;   // expected states, first in bits [3:0]
    int          n;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[13];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference outputs per state, written from the control table.
  function automatic ctrl_t exp_ctrl(input logic [3:0] st, input logic [5:0] fn,
                                     input logic z, input logic rst);
    ctrl_t c;
    c = '0;
    c.alu = 4'b0010;
    case (st)
      4'd0:  begin c.src_b = 2'b01; c.ir_write = 1; c.pc_en = 1; end
      4'd1:  c.src_b = 2'b11;
      4'd2:  begin c.src_a = 1; c.src_b = 2'b10; end
      4'd3:  c.iord = 1;
      4'd4:  begin c.memto_reg = 1; c.reg_write = 1; end
      4'd5:  begin c.iord = 1; c.mem_write = 1; end
      4'd6: begin
        c.src_a = 1;
        case (fn)
          6'b100000: c.alu = 4'b0010;
          6'b100010: c.alu = 4'b0110;
          6'b100100: c.alu = 4'b0000;
          6'b100101: c.alu = 4'b0011;
          6'b101010: c.alu = 4'b0111;
          default:   c.alu = 4'b1111;
        endcase
      end
      4'd7:  begin c.reg_dst = 1; c.reg_write = 1; end
      4'd8:  begin c.src_a = 1; c.alu = 4'b0110; c.pc_src = 2'b01; c.pc_en = z; end
      4'd9:  begin c.src_a = 1; c.src_b = 2'b10; end
      4'd10: c.reg_write = 1;
      4'd11: begin c.pc_src = 2'b10; c.pc_en = 1; end
      default: ;
    endcase
    if (rst) begin
      c.mem_write = 0; c.ir_write = 0; c.reg_write = 0; c.pc_en = 0;
    end
    return c;
  endfunction

  // Queue one cycle's expectation, then compare it against the DUT mid-cycle.
  task automatic expect_cycle(input string tag, input logic [3:0] st, input logic rst);
    exp_t  e;
    ctrl_t act;
    exp_q.push_back('{st, exp_ctrl(st, Funct, Zero, rst), exp_count});
    @(negedge clk);
    e   = exp_q.pop_front();
    act = '{IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, PCSrc, PCEn, ALUControl};
    check({tag, "/state"}, {28'd0, State}, {28'd0, e.state});
    check({tag, "/ctrl"},  {16'd0, act},   {16'd0, e.ctrl});
    check({tag, "/count"}, InstrCount,     e.count);
  endtask

  task automatic run_instr(input int idx, input vec_t v);
    Op = v.op; Funct = v.funct; Zero = v.zero;
    for (int k = 0; k < v.n; k++) begin
      expect_cycle($sformatf("v%0d.c%0d", idx, k), v.path[4*k +: 4], 1'b0);
      @(posedge clk); #1;
    end
    exp_count++;
  endtask

  initial begin
    vecs[0]  = '{6'h00, 6'h20, 1'b1, 24'h007610, 4};  // add (Zero ignored)
    vecs[1]  = '{6'h23, 6'h00, 1'b0, 24'h043210, 5};  // lw
    vecs[2]  = '{6'h2B, 6'h00, 1'b0, 24'h005210, 4};  // sw
    vecs[3]  = '{6'h04, 6'h00, 1'b1, 24'h000810, 3};  // beq taken
    vecs[4]  = '{6'h04, 6'h00, 1'b0, 24'h000810, 3};  // beq not taken
    vecs[5]  = '{6'h00, 6'h22, 1'b0, 24'h007610, 4};  // sub
    vecs[6]  = '{6'h00, 6'h24, 1'b0, 24'h007610, 4};  // and
    vecs[7]  = '{6'h00, 6'h25, 1'b0, 24'h007610, 4};  // or
    vecs[8]  = '{6'h00, 6'h2A, 1'b0, 24'h007610, 4};  // slt
    vecs[9]  = '{6'h00, 6'h00, 1'b0, 24'h007610, 4};  // unsupported funct
    vecs[10] = '{6'h08, 6'h00, 1'b0, 24'h00A910, 4};  // addi
    vecs[11] = '{6'h3F, 6'h00, 1'b0, 24'h000010, 2};  // illegal op -> NOP
    vecs[12] = '{6'h02, 6'h00, 1'b0, 24'h000B10, 3};  // j

    reset = 1'b1; Op = '0; Funct = '0; Zero = 1'b0;
    @(posedge clk);
    expect_cycle("reset", 4'd0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_instr(i, vecs[i]);

    // Abandon a lw in MEMRD with reset: no writeback, count cleared.
    Op = 6'h23; Funct = '0; Zero = 1'b0;
    expect_cycle("lw_abort.fetch", 4'd0, 1'b0);
    @(posedge clk); #1;
    expect_cycle("lw_abort.decode", 4'd1, 1'b0);
    @(posedge clk); #1;
    expect_cycle("lw_abort.memadr", 4'd2, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    expect_cycle("lw_abort.memrd_rst", 4'd3, 1'b1);
    @(posedge clk); #1;
    exp_count = 0;
    expect_cycle("lw_abort.fetch_rst", 4'd0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(13, vecs[12]);
    expect_cycle("after_abort", 4'd0, 1'b0);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
